// File: rtl/apu_bus_master.sv
// Sequenced CPU-style bus initiator for the APU register window FF10-FF3F.
// Optional feature: define APU_POWER_GUARD_EN to drop writes to 0x10-0x25 while the shadow power bit is 0.
module apu_bus_master #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        cpu_wr,
  output logic        cpu_rd,
  output logic        busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int MAX_SH = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_PH = (MAX_SH > HOLD_CYCLES) ? MAX_SH : HOLD_CYCLES;
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [PH_W-1:0]  PH_SETUP  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_STROBE = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_HOLD   = PH_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  // FIFO entry layout: {wr, addr[7:0], wdata[7:0]}
  logic [16:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic             r_is_wr;
  logic [7:0]       r_cap;
  logic [15:0]      r_a;
  logic [7:0]       r_d_out;
  logic             r_d_oe;
  logic             r_cpu_wr;
  logic             r_cpu_rd;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_push;
  logic             w_empty;
  logic             w_take;
  logic [16:0]      w_head;
  logic             w_hd_wr;
  logic [7:0]       w_hd_addr;
  logic [7:0]       w_hd_wdata;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_range;
  logic             w_drop;
  logic             w_busy_nxt;

  assign w_push  = req_valid && r_ready;
  assign w_empty = (r_cnt == '0);
  // An idle FSM takes a request straight off the port when the FIFO is empty,
  // so the address appears on the bus the cycle after the accept edge.
  assign w_take  = (r_state == S_IDLE) && (!w_empty || w_push);
  assign w_head  = w_empty ? {req_wr, req_addr, req_wdata} : r_mem[r_rd_ptr];
  assign {w_hd_wr, w_hd_addr, w_hd_wdata} = w_head;

  assign w_cnt_nxt  = r_cnt + CNT_W'(w_push) - CNT_W'(w_take);
  assign w_in_range = (w_hd_addr >= 8'h10) && (w_hd_addr <= 8'h3F);
  assign w_busy_nxt = ((r_state == S_IDLE) ? w_take : (r_state != S_RESP)) || (w_cnt_nxt != '0);

`ifdef APU_POWER_GUARD_EN
  logic r_pwr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwr <= 1'b0;
    end else if (w_take && w_hd_wr && (w_hd_addr == 8'h26)) begin
      r_pwr <= w_hd_wdata[7];
    end
  end

  assign w_drop = w_hd_wr && !r_pwr && (w_hd_addr >= 8'h10) && (w_hd_addr <= 8'h25);
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_wr, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_take) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CNT_FULL);
      r_busy  <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_a         <= 16'h0000;
      r_d_out     <= 8'h00;
      r_d_oe      <= 1'b0;
      r_cpu_wr    <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'hFF;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (w_in_range && !w_drop) begin
              r_state <= S_SETUP;
              r_phase <= PH_SETUP;
              r_a     <= {8'hFF, w_hd_addr};
              r_d_out <= w_hd_wdata;
              r_is_wr <= w_hd_wr;
            end else begin
              // Rejected or power-guarded requests skip the bus entirely.
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= !w_in_range;
              r_rsp_rdata <= 8'hFF;
            end
          end
        end
        S_SETUP: begin
          if (r_phase == '0) begin
            r_state  <= S_STROBE;
            r_phase  <= PH_STROBE;
            r_cpu_wr <= r_is_wr;
            r_cpu_rd <= !r_is_wr;
            r_d_oe   <= r_is_wr;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        S_STROBE: begin
          if (r_phase == '0) begin
            r_state  <= S_HOLD;
            r_phase  <= PH_HOLD;
            r_cpu_wr <= 1'b0;
            r_cpu_rd <= 1'b0;
            if (!r_is_wr) r_cap <= d_in;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        S_HOLD: begin
          if (r_phase == '0) begin
            r_state     <= S_RESP;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_is_wr ? 8'hFF : r_cap;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 8'hFF;
          r_a         <= 16'h0000;
          r_d_out     <= 8'h00;
          r_d_oe      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign a         = r_a;
  assign d_out     = r_d_out;
  assign d_oe      = r_d_oe;
  assign cpu_wr    = r_cpu_wr;
  assign cpu_rd    = r_cpu_rd;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/apu_bus_master.md
# apu_bus_master

Sequenced bus initiator that issues CPU-style read and write cycles to the APU register window FF10–FF3F. Requests arrive through a valid/ready port into a small FIFO. Each request becomes one timed bus cycle on `a`/`cpu_wr`/`cpu_rd`/data, and the block returns one response per request. It sits on the CPU side of the APU address decoder and drives the same `a[15:0]`, `cpu_wr` and `cpu_rd` nets the decoder consumes. It is used by the boot-sound player and by APU register test benches.

## Interface
Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2
- SETUP_CYCLES, 1, cycles the address is stable before the strobe; minimum 1
- STROBE_CYCLES, 2, cycles `cpu_wr`/`cpu_rd` is high; minimum 1
- HOLD_CYCLES, 1, cycles the address and data are held after the strobe; minimum 1

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept; high when not full
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  8  low address byte; the bus address is {8'hFF, req_addr}
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response pulse, exactly one per accepted request
- rsp_rdata  out  8  read data; 8'hFF for writes and errors
- rsp_err  out  1  request rejected; qualified by rsp_valid
- a  out  16  bus address; 16'h0000 when idle
- d_out  out  8  write data driven to the bus
- d_oe  out  1  d_out is valid; high only in STROBE and HOLD of a write
- d_in  in  8  read data returned from the bus
- cpu_wr  out  1  write strobe
- cpu_rd  out  1  read strobe
- busy  out  1  FSM not IDLE or FIFO not empty

## Operation
- FIFO:
  - A request is pushed on `req_valid && req_ready`.
  - `req_ready = !full`. It depends only on registered state, with no same-cycle bypass.
  - When the FIFO is full and pops in the same cycle, `req_ready` stays low that cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE with the FIFO non-empty pops the head entry:
  - `req_addr` in 0x10–0x3F: load the address and data registers, then go to SETUP.
  - Any other address: go to RESP with err=1. No bus activity occurs.
- SETUP: `a` is valid and both strobes are low. Lasts SETUP_CYCLES, then goes to STROBE.
- STROBE: `cpu_wr` (write) or `cpu_rd` (read) is high. Lasts STROBE_CYCLES.
  - For a read, `d_in` is captured on the edge that ends the last STROBE cycle.
- HOLD: strobes are low, `a` and `d_out` are unchanged. Lasts HOLD_CYCLES, then goes to RESP.
- RESP:
  - `rsp_valid` = 1 for one cycle. `rsp_rdata` = captured data for reads, 8'hFF otherwise.
  - Then go to IDLE, with `a` = 0 and `d_oe` = 0.
- `cpu_wr` and `cpu_rd` are never high together. A strobe never rises or falls in the same cycle that `a` changes.
- Responses are returned in request order.
- A single phase counter is sized for the largest of SETUP/STROBE/HOLD and reloads on each state change.

## Timing
- All outputs are registered.
- Reset values:
  - `a`=0, `d_out`=0, `d_oe`=0, `cpu_wr`=0, `cpu_rd`=0
  - `rsp_valid`=0, `rsp_rdata`=8'hFF, `rsp_err`=0
  - `busy`=0, `req_ready`=1
  - FIFO empty, FSM in IDLE
- Default cycle timeline, counting from the accept edge E0:
  - cycle 1: `a` valid (SETUP)
  - cycles 2–3: strobe high
  - cycle 4: HOLD
  - cycle 5: `rsp_valid`
  - cycle 6: IDLE
- Back-to-back throughput is one request per SETUP+STROBE+HOLD+2 cycles (6 cycles at defaults).
- An error request gives `rsp_valid` 2 cycles after the pop decision (IDLE pop cycle, then RESP).
- Reset asserted mid-operation:
  - On the next edge, strobes drop, `a` becomes 0 and the FIFO is flushed.
  - No response is emitted for in-flight or queued requests.

## Configuration
- APU_POWER_GUARD_EN defined:
  - The block keeps a shadow power bit, reset value 0. Writes issued to 0x26 update it from bit 7.
  - While the bit is 0, writes to 0x10–0x25 are dropped: no bus cycle, RESP with err=0.
  - Reads, writes to 0x26, and writes to wave RAM 0x30–0x3F always execute.
- APU_POWER_GUARD_EN undefined: no shadow bit exists, and every in-range write executes.

## Test plan
- Write 0x12←0xF3 at defaults:
  - `a`=FF12 from cycle 1; `cpu_wr` high in cycles 2–3; `d_oe` high in cycles 2–4.
  - `rsp_valid` in cycle 5 with err=0 and rdata=FF.
- Read 0x30 with `d_in`=0x5A during STROBE -> `cpu_rd` high for 2 cycles, then `rsp_rdata`=0x5A, err=0.
- Push 5 writes with FIFO_DEPTH=4 and the FSM stalled -> `req_ready` low after 4 accepts. All 5 responses arrive in order, 6 cycles apart.
- Request address 0x05, then 0x40 -> no strobe activity; two responses, each with err=1 and rdata=FF.
- Reset asserted during STROBE of a write with 2 queued -> next cycle `cpu_wr`=0, `a`=0, `busy`=0; no `rsp_valid` ever follows.
- With APU_POWER_GUARD_EN:
  - Write 0x11←0x80 after reset -> no `cpu_wr`; response err=0.
  - Then write 0x26←0x80 and 0x11←0x80 -> both appear on the bus.
